// File: rtl/notch_cfg_pkg.sv
// Purpose : shared constants for the notch filter configuration controller.
// Latency : n/a (constants only).
// Backpressure: n/a.
package notch_cfg_pkg;

  // Register byte offsets (all word aligned).
  localparam int OFF_CTRL   = 'h00;
  localparam int OFF_DIV    = 'h04;
  localparam int OFF_B0     = 'h08;
  localparam int OFF_B1     = 'h0C;
  localparam int OFF_B2     = 'h10;
  localparam int OFF_A1     = 'h14;
  localparam int OFF_A2     = 'h18;
  localparam int OFF_STATUS = 'h1C;

  // CTRL bit indices.
  localparam int CTRL_ENABLE = 0;
  localparam int CTRL_BYPASS = 1;
  localparam int CTRL_COMMIT = 2;

  // STATUS field positions.
  localparam int STAT_PENDING = 0;
  localparam int STAT_CNT_LSB = 8;
  localparam int STAT_CNT_W   = 8;

  // Coefficient field order: entry 0 (b0) sits in the MSBs of the packed
  // filter_coeff bus, entry NUM_COEFF-1 (a2) in the LSBs.
  localparam int NUM_COEFF = 5;
  localparam int COEFF_OFF [NUM_COEFF] = '{OFF_B0, OFF_B1, OFF_B2, OFF_A1, OFF_A2};

endpackage

// File: rtl/notch_cfg_div.sv
// Purpose : sample-rate divider; counts 0..div and strobes en when count==div.
// Latency : en is combinational from the count register; clr takes effect at the next edge.
// Backpressure: none.
// Ports: CLK/rst_n clock and async active-low reset; enable gates counting
//        (count held at 0 when low); div terminal count; clr restarts count at 0;
//        en one-cycle sample strobe.
module notch_cfg_div
  import notch_cfg_pkg::*;
#(
  parameter int DIV_W = 8
) (
  input  logic             CLK,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DIV_W-1:0] div,
  input  logic             clr,
  output logic             en
);

  logic [DIV_W-1:0] cnt;

  // div==0 gives a strobe on every enabled cycle.
  assign en = enable & (cnt == div);

  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || !enable || en) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/notch_cfg_ctrl.sv
// Purpose : APB config slave for one IIR notch filter; shadow/active coefficient banks,
//           atomic commit on a sample boundary, sample strobe divider and bypass control.
// Latency : writes land on the completing APB edge; reads/PSLVERR combinational in access phase.
// Backpressure: none, PREADY tied high (zero wait states).
// Ports: CLK/rst_n clock and async active-low reset; PSEL..PSLVERR APB slave;
//        filter_coeff active {b0,b1,b2,a1,a2} b0 in MSBs; EN sample strobe; bypass filter bypass.
module notch_cfg_ctrl
  import notch_cfg_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIV_W  = 8,
  parameter int ADDR_W = 5
) (
  input  logic                       CLK,
  input  logic                       rst_n,
  input  logic                       PSEL,
  input  logic                       PENABLE,
  input  logic                       PWRITE,
  input  logic [ADDR_W-1:0]          PADDR,
  input  logic [31:0]                PWDATA,
  output logic [31:0]                PRDATA,
  output logic                       PREADY,
  output logic                       PSLVERR,
  output logic [NUM_COEFF*WIDTH-1:0] filter_coeff,
  output logic                       EN,
  output logic                       bypass
);

  logic                  enable_q;
  logic                  bypass_q;
  logic [DIV_W-1:0]      div_q;
  logic [WIDTH-1:0]      shadow [NUM_COEFF];
  logic [WIDTH-1:0]      active [NUM_COEFF];
  logic                  commit_pending;
  logic [STAT_CNT_W-1:0] commit_cnt;

  logic                  access;
  logic                  misaligned;
  logic                  sel_ctrl;
  logic                  sel_div;
  logic                  sel_status;
  logic [NUM_COEFF-1:0]  coef_sel;
  logic                  wr;
  logic                  div_en;
  logic                  commit_apply;
  logic                  unused_pwdata;

  assign PREADY        = 1'b1;
  assign unused_pwdata = ^PWDATA[31:WIDTH];

  // ---------------- APB decode ----------------
  assign access     = PSEL & PENABLE;
  assign misaligned = |PADDR[1:0];
  assign sel_ctrl   = (PADDR == ADDR_W'(OFF_CTRL));
  assign sel_div    = (PADDR == ADDR_W'(OFF_DIV));
  assign sel_status = (PADDR == ADDR_W'(OFF_STATUS));

  always_comb begin
    coef_sel = '0;
    for (int i = 0; i < NUM_COEFF; i++) begin
      coef_sel[i] = (PADDR == ADDR_W'(COEFF_OFF[i]));
    end
  end

  // Only writes can fault; shadow writes are refused while a commit is in
  // flight so the bank being copied cannot change underneath it.
  assign PSLVERR = access & PWRITE &
                   (misaligned | sel_status | ((|coef_sel) & commit_pending));
  assign wr      = access & PWRITE & ~PSLVERR;

  // ---------------- read mux ----------------
  always_comb begin
    PRDATA = '0;
    if (access && !PWRITE) begin
      if (sel_ctrl) begin
        PRDATA[CTRL_ENABLE] = enable_q;
        PRDATA[CTRL_BYPASS] = bypass_q;
      end
      if (sel_div) begin
        PRDATA[DIV_W-1:0] = div_q;
      end
      if (sel_status) begin
        PRDATA[STAT_PENDING]                  = commit_pending;
        PRDATA[STAT_CNT_LSB +: STAT_CNT_W]    = commit_cnt;
      end
      for (int i = 0; i < NUM_COEFF; i++) begin
        if (coef_sel[i]) begin
          PRDATA = {{(32-WIDTH){shadow[i][WIDTH-1]}}, shadow[i]};
        end
      end
    end
  end

  // ---------------- divider ----------------
  notch_cfg_div #(
    .DIV_W (DIV_W)
  ) u_div (
    .CLK    (CLK),
    .rst_n  (rst_n),
    .enable (enable_q),
    .div    (div_q),
    .clr    (wr & sel_div),
    .en     (div_en)
  );

  assign EN = div_en;

  // A pending commit lands on the edge that closes an EN cycle, so the filter
  // uses the new set from its next sample on. With the divider stopped there is
  // no sample boundary to wait for, so it lands on the next edge.
  assign commit_apply = commit_pending & (div_en | ~enable_q);

  // ---------------- register state ----------------
  always_ff @(posedge CLK or negedge rst_n) begin
    if (!rst_n) begin
      enable_q       <= 1'b0;
      bypass_q       <= 1'b1;
      div_q          <= '0;
      commit_pending <= 1'b0;
      commit_cnt     <= '0;
      for (int i = 0; i < NUM_COEFF; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else begin
      if (wr && sel_ctrl) begin
        enable_q <= PWDATA[CTRL_ENABLE];
        bypass_q <= PWDATA[CTRL_BYPASS];
      end
      if (wr && sel_div) begin
        div_q <= PWDATA[DIV_W-1:0];
      end
      for (int i = 0; i < NUM_COEFF; i++) begin
        if (wr && coef_sel[i]) begin
          shadow[i] <= PWDATA[WIDTH-1:0];
        end
      end
      // A commit request while one is already pending is absorbed silently.
      if (commit_apply) begin
        active         <= shadow;
        commit_pending <= 1'b0;
        commit_cnt     <= commit_cnt + STAT_CNT_W'(1);
      end else if (wr && sel_ctrl && PWDATA[CTRL_COMMIT]) begin
        commit_pending <= 1'b1;
      end
    end
  end

  assign bypass = bypass_q;

  always_comb begin
    filter_coeff = '0;
    for (int i = 0; i < NUM_COEFF; i++) begin
      filter_coeff[(NUM_COEFF-1-i)*WIDTH +: WIDTH] = active[i];
    end
  end

endmodule
